gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised successor of the instruction-fetch branch predictor. It predicts conditional branches
//  with a 2-bit saturating-counter PHT, in bimodal or gshare mode. Speculative global history is
//  checkpointed per in-flight branch in a resolution queue, restored on mispredict, and counted.
//  Sits between decoder and fetch-order queue (FOQ); resolution arrives from the CDB.
// PARAMETERS
//  PHT_IDX_W  6  log2 PHT entries; index bits pc[PHT_IDX_W:1]
//  GHR_W      6  global history length; must be <= PHT_IDX_W (GHR zero-extended for XOR)
//  Q_DEPTH_W  3  log2 in-flight queue depth (DEPTH = 1<<Q_DEPTH_W)
//  MODE       1  0 = bimodal (idx = pc bits), 1 = gshare (idx = pc bits ^ GHR)
// PORTS
//  clk_in         in   1   clock, all state on posedge
//  rst_n_in       in   1   asynchronous active-low reset
//  rdy_in         in   1   global ready; low = freeze all state, gate predict/fail outputs to 0
//  branch         in   1   decoded conditional branch at pc_in
//  imm            in   32  branch offset
//  inst_length    in   1   1 = 4-byte inst, 0 = 2-byte (compressed)
//  foq_full       in   1   downstream FOQ full; blocks prediction
//  pc_in          in   32  pc of the decoded inst
//  cdb_active     in   1   CDB broadcast valid
//  cdb_addr       in   32  source pc of the broadcast
//  cdb_val        in   32  bit 0 = actual taken
//  need_branch    out  1   predicted taken (comb)
//  branch_addr    out  32  predicted next pc (comb; 0 when no prediction)
//  bp_full        out  1   queue holds DEPTH entries (registered count == DEPTH)
//  predict_fail   out  1   head branch resolved opposite to prediction (comb)
//  fail_addr      out  32  correct pc on predict_fail, else 0
//  stat_branches  out  32  resolved-branch count, saturating
//  stat_misses    out  32  mispredict count, saturating
// BEHAVIOUR
//  - Reset (async assert, sync-free deassert): PHT all 2'b01 (WNT), GHR 0, front/rear/count 0,
//    stats 0; comb outputs therefore 0 (queue empty, no predict).
//  - do_pred = branch & rdy_in & !foq_full & !bp_full & !predict_fail.
//  - idx = pc_in[PHT_IDX_W:1] ^ (MODE ? {0,GHR} : 0); need_branch = do_pred & pht[idx][1].
//  - branch_addr = taken ? pc_in+imm : pc_in+(inst_length?4:2); fail target = the other; 32-bit wrap.
//  - Push (do_pred), zero latency visible next cycle: entry {pc, fail target, taken, idx, GHR}
//    at rear; rear wraps DEPTH-1 -> 0; GHR <= {GHR[GHR_W-2:0], taken}.
//  - Resolve: resolve = rdy_in & cdb_active & count!=0 & cdb_addr==head.pc & cdb_addr!=0.
//    PHT[head.idx] saturating +1 if cdb_val[0], -1 otherwise (3 and 0 stick). Stored idx is used,
//    not recomputed. Non-matching broadcasts are ignored.
//  - Correct resolve: pop head, front wraps; stat_branches +1.
//  - Mispredict (resolve & head.taken != cdb_val[0]): predict_fail=1 and fail_addr=head.fail in
//    that cycle. Next cycle: queue flushed (front=rear=count=0); GHR <= {head.ghr[GHR_W-2:0],
//    actual}; stat_branches and stat_misses +1. Any push that cycle is suppressed by do_pred.
//  - Push and correct pop in the same cycle: count unchanged; both pointers advance.
//  - Full: no push even if a pop occurs the same cycle (conservative; bp_full from registered count).
//  - Same-cycle PHT update and prediction on the same idx: prediction reads the old value.
//  - rdy_in low: no state change, outputs gated; a CDB broadcast in that cycle is lost.
//  - Reset mid-operation: all in-flight entries dropped, history cleared, stats cleared.
// STRUCTURE
//  - src/macros.v: BP_CNT_SNT/WNT/WT/ST encodings, BP_CNT_INIT (= WNT), queue entry field offsets.
//  - Sub-module bp_pht: 2-bit counter array with one comb read port (predict) and one
//    saturating update port (idx, taken, en), async active-low reset to BP_CNT_INIT.
//  - Top: index hash, GHR, circular queue with count, stat counters.
// TESTING
//  - Reset, then branch at pc=0x100, imm=0x20, len=4 -> need_branch=0, branch_addr=0x104, count=1.
//  - Resolve 0x100 taken twice (two pushes): PHT[idx] 01->10->11; 3rd predict at 0x100
//    (bimodal) -> need_branch=1, branch_addr=0x120.
//  - Mispredict: queue holds 3 entries; CDB head taken!=pred -> predict_fail=1, fail_addr=head
//    alt target; next cycle count=0, GHR=snapshot<<1|actual, stat_misses=1.
//  - Fill DEPTH=8 entries -> bp_full=1, 9th branch yields need_branch=0, no push; one pop -> resumes.
//  - Wrap: 20 push/pop pairs with simultaneous push+pop -> pointers wrap, count stable, FIFO order.
//  - gshare: same pc with GHR=0 vs GHR=6'b000001 hits distinct PHT entries; rdy_in=0 freezes all.

Source files
------------

// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types for the gshare branch predictor: 2-bit counter encodings and small helpers.
package gshare_branch_predictor_pkg;

    typedef enum logic [1:0] {
        CntSnt = 2'b00,
        CntWnt = 2'b01,
        CntWt  = 2'b10,
        CntSt  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e CntInit = CntWnt;

    // Saturating 2-bit counter step; strong states stick.
    function automatic bp_cnt_e cnt_update(bp_cnt_e cnt, logic taken);
        bp_cnt_e nxt;
        nxt = cnt;
        unique case (cnt)
            CntSnt: nxt = taken ? CntWnt : CntSnt;
            CntWnt: nxt = taken ? CntWt  : CntSnt;
            CntWt:  nxt = taken ? CntSt  : CntWnt;
            CntSt:  nxt = taken ? CntSt  : CntWt;
            default: nxt = CntInit;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht.sv
// Pattern history table: 2-bit counters with one combinational read port and one update port.
module gshare_branch_predictor_pht
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_cnt_e          rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned Entries = 1 << IDX_W;

    bp_cnt_e cnt_q [Entries];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= CntInit;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= cnt_update(cnt_q[upd_idx], upd_taken);
        end
    end

    // Read sees the pre-update value when read and update collide.
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare conditional branch predictor with per-branch history checkpoints in a
// resolution queue, mispredict recovery and saturating statistics.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned PHT_IDX_W = 6,
    parameter int unsigned GHR_W     = 6,
    parameter int unsigned Q_DEPTH_W = 3,
    parameter int unsigned MODE      = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        branch,
    input  logic [31:0] imm,
    input  logic        inst_length,
    input  logic        foq_full,
    input  logic [31:0] pc_in,
    input  logic        cdb_active,
    input  logic [31:0] cdb_addr,
    input  logic [31:0] cdb_val,
    output logic        need_branch,
    output logic [31:0] branch_addr,
    output logic        bp_full,
    output logic        predict_fail,
    output logic [31:0] fail_addr,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_misses
);

    localparam int unsigned DEPTH = 1 << Q_DEPTH_W;
    localparam logic [Q_DEPTH_W:0] FullCnt = {1'b1, {Q_DEPTH_W{1'b0}}};

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          fail;
        logic                 taken;
        logic [PHT_IDX_W-1:0] idx;
        logic [GHR_W-1:0]     ghr;
    } entry_t;

    entry_t               q_mem [DEPTH];
    entry_t               head;
    entry_t               new_entry;
    logic [Q_DEPTH_W-1:0] front_q, front_d, rear_q, rear_d;
    logic [Q_DEPTH_W:0]   count_q, count_d;
    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [31:0]          sb_q, sb_d, sm_q, sm_d;

    logic [PHT_IDX_W-1:0] ghr_ext, pred_idx;
    bp_cnt_e              pht_cnt;
    logic                 pred_taken, do_pred, resolve, mispred, actual;
    logic [31:0]          target_taken, target_seq;
    logic                 unused_bits;

    gshare_branch_predictor_pht #(
        .IDX_W(PHT_IDX_W)
    ) u_pht (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rd_idx    (pred_idx),
        .rd_cnt    (pht_cnt),
        .upd_en    (resolve),
        .upd_idx   (head.idx),
        .upd_taken (actual)
    );

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr_q;
    end

    assign pred_idx     = pc_in[PHT_IDX_W:1] ^ ((MODE != 0) ? ghr_ext : '0);
    assign pred_taken   = pht_cnt[1];
    assign target_taken = pc_in + imm;
    assign target_seq   = pc_in + (inst_length ? 32'd4 : 32'd2);

    assign head    = q_mem[front_q];
    assign actual  = cdb_val[0];
    assign resolve = rdy_in & cdb_active & (count_q != '0) & (cdb_addr == head.pc) &
                     (cdb_addr != 32'd0);
    assign mispred = resolve & (head.taken != actual);
    assign bp_full = (count_q == FullCnt);
    assign do_pred = branch & rdy_in & ~foq_full & ~bp_full & ~mispred;

    assign need_branch   = do_pred & pred_taken;
    assign branch_addr   = do_pred ? (pred_taken ? target_taken : target_seq) : 32'd0;
    assign predict_fail  = mispred;
    assign fail_addr     = mispred ? head.fail : 32'd0;
    assign stat_branches = sb_q;
    assign stat_misses   = sm_q;

    assign new_entry = '{
        pc:    pc_in,
        fail:  pred_taken ? target_seq : target_taken,
        taken: pred_taken,
        idx:   pred_idx,
        ghr:   ghr_q
    };

    always_comb begin
        front_d = front_q;
        rear_d  = rear_q;
        count_d = count_q;
        ghr_d   = ghr_q;
        sb_d    = sb_q;
        sm_d    = sm_q;
        if (mispred) begin
            // Flush everything younger and rebuild history from the branch's own checkpoint.
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
            ghr_d   = {head.ghr[GHR_W-2:0], actual};
            sb_d    = sat_inc(sb_q);
            sm_d    = sat_inc(sm_q);
        end else begin
            if (resolve) begin
                front_d = front_q + 1'b1;
                sb_d    = sat_inc(sb_q);
            end
            if (do_pred) begin
                rear_d = rear_q + 1'b1;
                ghr_d  = {ghr_q[GHR_W-2:0], pred_taken};
            end
            unique case ({do_pred, resolve})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
            ghr_q   <= '0;
            sb_q    <= '0;
            sm_q    <= '0;
        end else if (rdy_in) begin
            front_q <= front_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            ghr_q   <= ghr_d;
            sb_q    <= sb_d;
            sm_q    <= sm_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (do_pred) begin
            q_mem[rear_q] <= new_entry;
        end
    end

    assign unused_bits = ^{pc_in[31:PHT_IDX_W+1], pc_in[0], cdb_val[31:1], pht_cnt[0],
                           head.ghr[GHR_W-1]};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: a bimodal and a gshare instance share stimulus; expectations are hand-computed.
module tb_gshare_branch_predictor;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] imm = '0;
    logic        inst_length = 1'b1;
    logic        foq_full = 1'b0;
    logic [31:0] pc_in = '0;
    logic        cdb_active = 1'b0;
    logic [31:0] cdb_addr = '0;
    logic [31:0] cdb_val = '0;

    logic        b_need, b_full, b_fail, g_need, g_full, g_fail;
    logic [31:0] b_addr, b_faddr, b_sb, b_sm, g_addr, g_faddr, g_sb, g_sm;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    gshare_branch_predictor #(
        .PHT_IDX_W(6), .GHR_W(6), .Q_DEPTH_W(3), .MODE(0)
    ) u_bim (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .branch(branch), .imm(imm),
        .inst_length(inst_length), .foq_full(foq_full), .pc_in(pc_in),
        .cdb_active(cdb_active), .cdb_addr(cdb_addr), .cdb_val(cdb_val),
        .need_branch(b_need), .branch_addr(b_addr), .bp_full(b_full),
        .predict_fail(b_fail), .fail_addr(b_faddr), .stat_branches(b_sb), .stat_misses(b_sm)
    );

    gshare_branch_predictor #(
        .PHT_IDX_W(6), .GHR_W(6), .Q_DEPTH_W(3), .MODE(1)
    ) u_gsh (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .branch(branch), .imm(imm),
        .inst_length(inst_length), .foq_full(foq_full), .pc_in(pc_in),
        .cdb_active(cdb_active), .cdb_addr(cdb_addr), .cdb_val(cdb_val),
        .need_branch(g_need), .branch_addr(g_addr), .bp_full(g_full),
        .predict_fail(g_fail), .fail_addr(g_faddr), .stat_branches(g_sb), .stat_misses(g_sm)
    );

    typedef struct packed {
        logic        br;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        len;
        logic        foq;
        logic        rdy;
        logic        cdb;
        logic [31:0] caddr;
        logic        cval;
        logic        e_need;
        logic [31:0] e_addr;
        logic        e_fail;
        logic [31:0] e_faddr;
        logic [31:0] e_sb;
        logic [31:0] e_sm;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] pc, input logic [31:0] im,
                         input logic len, input logic foq, input logic rdy, input logic cdb,
                         input logic [31:0] caddr, input logic cval);
        branch = br; pc_in = pc; imm = im; inst_length = len; foq_full = foq; rdy_in = rdy;
        cdb_active = cdb; cdb_addr = caddr; cdb_val = {31'd0, cval};
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n_in = 1'b0;
        #2;
        chk("rst need", {31'd0, b_need}, 32'd0);
        chk("rst addr", b_addr, 32'd0);
        chk("rst full", {31'd0, b_full}, 32'd0);
        chk("rst fail", {31'd0, b_fail}, 32'd0);
        chk("rst faddr", b_faddr, 32'd0);
        chk("rst sb", b_sb, 32'd0);
        chk("rst sm", b_sm, 32'd0);
        next_cycle();
        rst_n_in = 1'b1;
    endtask

    function automatic vec_t mk(input logic br, input logic [31:0] pc, input logic [31:0] im,
                                input logic len, input logic foq, input logic rdy,
                                input logic cdb, input logic [31:0] caddr, input logic cval,
                                input logic e_need, input logic [31:0] e_addr,
                                input logic e_fail, input logic [31:0] e_faddr,
                                input logic [31:0] e_sb, input logic [31:0] e_sm);
        vec_t v;
        v = '{br, pc, im, len, foq, rdy, cdb, caddr, cval, e_need, e_addr, e_fail, e_faddr,
              e_sb, e_sm};
        return v;
    endfunction

    initial begin
        // Bimodal walk: pc 0x100 -> idx 0, pc 0x202 -> idx 1, pc 0x300 -> idx 0.
        vecs[0]  = mk(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0,  0, 32'h104, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1, 1, 32'h100, 1,       0, 0, 1, 32'h120, 0, 0);
        vecs[2]  = mk(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0,  1, 32'h120, 0, 0, 1, 1);
        vecs[3]  = mk(1, 32'h100, 32'h20, 1, 0, 1, 1, 32'h100, 1, 1, 32'h120, 0, 0, 1, 1);
        vecs[4]  = mk(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0,  1, 32'h120, 0, 0, 2, 1);
        vecs[5]  = mk(1, 32'h202, 32'h40, 0, 0, 1, 0, 0, 0,  0, 32'h204, 0, 0, 2, 1);
        vecs[6]  = mk(1, 32'h300, 32'hFFFF_FFF0, 1, 0, 1, 0, 0, 0, 1, 32'h2F0, 0, 0, 2, 1);
        vecs[7]  = mk(0, 0, 0, 1, 0, 1, 1, 32'h202, 0,       0, 0, 0, 0, 2, 1);
        vecs[8]  = mk(1, 32'h400, 32'h20, 1, 0, 1, 1, 32'h100, 0, 0, 0, 1, 32'h104, 2, 1);
        vecs[9]  = mk(0, 0, 0, 1, 0, 1, 1, 32'h202, 0,       0, 0, 0, 0, 3, 2);
        vecs[10] = mk(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0,  1, 32'h120, 0, 0, 3, 2);
        vecs[11] = mk(1, 32'h100, 32'h20, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 3, 2);
        vecs[12] = mk(0, 0, 0, 1, 0, 1, 1, 32'h100, 0,       0, 0, 1, 32'h104, 3, 2);
        vecs[13] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0,             0, 0, 0, 0, 4, 3);
        vecs[14] = mk(1, 32'h100, 32'h20, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 4, 3);
        vecs[15] = mk(0, 0, 0, 1, 0, 1, 1, 32'h100, 1,       0, 0, 0, 0, 4, 3);

        #1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].br, vecs[i].pc, vecs[i].imm, vecs[i].len, vecs[i].foq,
                  vecs[i].rdy, vecs[i].cdb, vecs[i].caddr, vecs[i].cval);
            @(negedge clk_in);
            chk($sformatf("v%0d need", i), {31'd0, b_need}, {31'd0, vecs[i].e_need});
            chk($sformatf("v%0d addr", i), b_addr, vecs[i].e_addr);
            chk($sformatf("v%0d fail", i), {31'd0, b_fail}, {31'd0, vecs[i].e_fail});
            chk($sformatf("v%0d faddr", i), b_faddr, vecs[i].e_faddr);
            chk($sformatf("v%0d full", i), {31'd0, b_full}, 32'd0);
            chk($sformatf("v%0d sb", i), b_sb, vecs[i].e_sb);
            chk($sformatf("v%0d sm", i), b_sm, vecs[i].e_sm);
            next_cycle();
        end

        // Mid-operation reset clears stats and queue; then fill to DEPTH.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 32'h10, 1, 0, 1, 0, 0, 0);
            @(negedge clk_in);
            chk($sformatf("fill%0d full", i), {31'd0, b_full}, 32'd0);
            chk($sformatf("fill%0d addr", i), b_addr, 32'h1000 + 32'(4 * i) + 32'd4);
            next_cycle();
        end
        drive(1, 32'h1020, 32'h10, 1, 0, 1, 0, 0, 0);
        @(negedge clk_in);
        chk("full flag", {31'd0, b_full}, 32'd1);
        chk("full blocks addr", b_addr, 32'd0);
        next_cycle();
        drive(1, 32'h1020, 32'h10, 1, 0, 1, 1, 32'h1000, 0);
        @(negedge clk_in);
        chk("full pop no push", b_addr, 32'd0);
        chk("full pop fail", {31'd0, b_fail}, 32'd0);
        next_cycle();
        drive(1, 32'h2000, 32'h10, 1, 0, 1, 0, 0, 0);
        @(negedge clk_in);
        chk("resume full", {31'd0, b_full}, 32'd0);
        chk("resume addr", b_addr, 32'h2004);
        next_cycle();
        idle();
        @(negedge clk_in);
        chk("refull", {31'd0, b_full}, 32'd1);
        chk("fill sb", b_sb, 32'd1);

        // Wrap: simultaneous push/pop keeps count at one and pointers cycle twice.
        do_reset();
        drive(1, 32'h3000, 32'h10, 1, 0, 1, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h3000 + 32'(4 * (i + 1)), 32'h10, 1, 0, 1, 1, 32'h3000 + 32'(4 * i), 0);
            @(negedge clk_in);
            chk($sformatf("wrap%0d addr", i), b_addr, 32'h3000 + 32'(4 * (i + 1)) + 32'd4);
            chk($sformatf("wrap%0d fail", i), {31'd0, b_fail}, 32'd0);
            chk($sformatf("wrap%0d sb", i), b_sb, 32'(i));
            next_cycle();
        end
        drive(0, 0, 0, 1, 0, 1, 1, 32'h3050, 1);
        @(negedge clk_in);
        chk("wrap full", {31'd0, b_full}, 32'd0);
        chk("wrap last fail", {31'd0, b_fail}, 32'd1);
        chk("wrap last faddr", b_faddr, 32'h3060);
        next_cycle();
        idle();
        @(negedge clk_in);
        chk("wrap sb", b_sb, 32'd21);
        chk("wrap sm", b_sm, 32'd1);

        // gshare vs bimodal: mispredict restores GHR to 1, so pc 0x100 now indexes entry 1.
        do_reset();
        drive(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0);
        @(negedge clk_in);
        chk("g0 need", {31'd0, g_need}, 32'd0);
        chk("g0 addr", g_addr, 32'h104);
        next_cycle();
        drive(0, 0, 0, 1, 0, 1, 1, 32'h100, 1);
        @(negedge clk_in);
        chk("g1 fail", {31'd0, g_fail}, 32'd1);
        chk("g1 faddr", g_faddr, 32'h120);
        next_cycle();
        drive(1, 32'h100, 32'h20, 1, 0, 0, 1, 32'h100, 1);
        @(negedge clk_in);
        chk("g2 frozen addr", g_addr, 32'd0);
        chk("g2 frozen fail", {31'd0, g_fail}, 32'd0);
        next_cycle();
        drive(1, 32'h100, 32'h20, 1, 0, 1, 0, 0, 0);
        @(negedge clk_in);
        chk("g3 gsh need", {31'd0, g_need}, 32'd0);
        chk("g3 gsh addr", g_addr, 32'h104);
        chk("g3 bim need", {31'd0, b_need}, 32'd1);
        chk("g3 bim addr", b_addr, 32'h120);
        next_cycle();
        drive(1, 32'h104, 32'h20, 1, 0, 1, 0, 0, 0);
        @(negedge clk_in);
        chk("g4 gsh addr", g_addr, 32'h124);
        chk("g4 bim addr", b_addr, 32'h108);
        chk("g4 gsh sm", g_sm, 32'd1);
        next_cycle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
